// File: rtl/trace_reg_arbiter.sv
// trace_reg_arbiter
//   Shares the trace register-block slave port between two masters in the
//   usb_clk domain. M0 is the USB register front-end and M1 is an on-chip
//   configuration master. The arbiter grants whole transactions and
//   alternates between the masters when both request. An owner that stops
//   strobing for pTIMEOUT owned cycles loses the bus. It is then masked
//   until it lets go of its request.
//
// Ports
//   usb_clk, reset_n              clock, asynchronous active-low reset
//   mN_req / mN_gnt               per-master request and registered grant
//   mN_address, mN_bytecnt,       per-master register access fields,
//   mN_write_data, mN_reg_read,   forwarded only while that master owns
//   mN_reg_write, mN_reg_addrvalid
//   mN_read_data                  slave read data, zero unless owner
//   reg_* / write_data            slave-side request fields
//   read_data                     slave read data (combinational)
//   I_clear_status                clears O_timeout and O_dropped_count
//   O_owner                       00 none, 01 M0, 10 M1 (registered)
//   O_timeout                     sticky: a grant was revoked
//   O_dropped_count               saturating count of non-owner strobe cycles
module trace_reg_arbiter #(
  parameter int pADDR_WIDTH   = 21,
  parameter int pBYTECNT_SIZE = 7,
  parameter int pTIMEOUT      = 1024,
  parameter int pTO_WIDTH     = 16
) (
  input  logic                                 usb_clk,
  input  logic                                 reset_n,

  input  logic                                 m0_req,
  output logic                                 m0_gnt,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] m0_address,
  input  logic [pBYTECNT_SIZE-1:0]             m0_bytecnt,
  input  logic [7:0]                           m0_write_data,
  input  logic                                 m0_reg_read,
  input  logic                                 m0_reg_write,
  input  logic                                 m0_reg_addrvalid,
  output logic [7:0]                           m0_read_data,

  input  logic                                 m1_req,
  output logic                                 m1_gnt,
  input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] m1_address,
  input  logic [pBYTECNT_SIZE-1:0]             m1_bytecnt,
  input  logic [7:0]                           m1_write_data,
  input  logic                                 m1_reg_read,
  input  logic                                 m1_reg_write,
  input  logic                                 m1_reg_addrvalid,
  output logic [7:0]                           m1_read_data,

  output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
  output logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
  output logic [7:0]                           write_data,
  output logic                                 reg_read,
  output logic                                 reg_write,
  output logic                                 reg_addrvalid,
  input  logic [7:0]                           read_data,

  input  logic                                 I_clear_status,
  output logic [1:0]                           O_owner,
  output logic                                 O_timeout,
  output logic [7:0]                           O_dropped_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] OWN0   = 2'd1;
  localparam logic [1:0] OWN1   = 2'd2;
  localparam logic [1:0] REVOKE = 2'd3;

  localparam logic [pTO_WIDTH:0] TIMEOUT_W = (pTO_WIDTH+1)'(pTIMEOUT);
  localparam logic [pTO_WIDTH:0] ONE_W     = (pTO_WIDTH+1)'(1);

  logic [1:0]           state, state_next;
  logic                 last_owner, last_next;   // 0 = M0, 1 = M1
  logic [1:0]           mask, mask_next;
  logic [pTO_WIDTH-1:0] stall_cnt, stall_next;
  logic [pTO_WIDTH:0]   stall_inc;
  logic [1:0]           owner_q;
  logic [1:0]           elig;
  logic                 own_req, own_read, own_write;
  logic                 drop_evt;

  // A masked master stays ineligible even while it keeps its request high.
  assign elig      = {m1_req, m0_req} & ~mask;
  assign stall_inc = {1'b0, stall_cnt} + ONE_W;

  // View of the current owner's request and strobes.
  always_comb begin
    own_req   = 1'b0;
    own_read  = 1'b0;
    own_write = 1'b0;
    case (state)
      OWN0: begin
        own_req   = m0_req;
        own_read  = m0_reg_read;
        own_write = m0_reg_write;
      end
      OWN1: begin
        own_req   = m1_req;
        own_read  = m1_reg_read;
        own_write = m1_reg_write;
      end
      default: ;
    endcase
  end

  // Slave-side mux. A simultaneous read+write from the owner goes out as a write.
  always_comb begin
    reg_address   = '0;
    reg_bytecnt   = '0;
    write_data    = '0;
    reg_read      = 1'b0;
    reg_write     = 1'b0;
    reg_addrvalid = 1'b0;
    m0_read_data  = '0;
    m1_read_data  = '0;
    case (state)
      OWN0: begin
        reg_address   = m0_address;
        reg_bytecnt   = m0_bytecnt;
        write_data    = m0_write_data;
        reg_write     = m0_reg_write;
        reg_read      = m0_reg_read & ~m0_reg_write;
        reg_addrvalid = m0_reg_addrvalid;
        m0_read_data  = read_data;
      end
      OWN1: begin
        reg_address   = m1_address;
        reg_bytecnt   = m1_bytecnt;
        write_data    = m1_write_data;
        reg_write     = m1_reg_write;
        reg_read      = m1_reg_read & ~m1_reg_write;
        reg_addrvalid = m1_reg_addrvalid;
        m1_read_data  = read_data;
      end
      default: ;
    endcase
  end

  // Next-state logic. last_owner records every grant, so it also names the
  // master being revoked while in REVOKE. Mask bits drop whenever the request
  // is seen low, but setting a mask bit on revoke takes priority over that.
  always_comb begin
    state_next = state;
    last_next  = last_owner;
    stall_next = stall_cnt;
    mask_next  = mask & {m1_req, m0_req};
    case (state)
      IDLE: begin
        if (elig == 2'b11) begin
          state_next = last_owner ? OWN0 : OWN1;
          last_next  = ~last_owner;
          stall_next = '0;
        end else if (elig[0]) begin
          state_next = OWN0;
          last_next  = 1'b0;
          stall_next = '0;
        end else if (elig[1]) begin
          state_next = OWN1;
          last_next  = 1'b1;
          stall_next = '0;
        end
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          state_next = IDLE;
        end else if (own_read || own_write) begin
          stall_next = '0;
        end else begin
          stall_next = stall_inc[pTO_WIDTH-1:0];
          if ((pTIMEOUT != 0) && (stall_inc >= TIMEOUT_W)) state_next = REVOKE;
        end
      end
      default: begin
        state_next            = IDLE;
        mask_next[last_owner] = 1'b1;
      end
    endcase
  end

  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      mask       <= 2'b00;
      stall_cnt  <= '0;
      owner_q    <= 2'b00;
    end else begin
      state      <= state_next;
      last_owner <= last_next;
      mask       <= mask_next;
      stall_cnt  <= stall_next;
      owner_q    <= {state_next == OWN1, state_next == OWN0};
    end
  end

  assign m0_gnt  = owner_q[0];
  assign m1_gnt  = owner_q[1];
  assign O_owner = owner_q;

  // Outside IDLE/REVOKE only the non-owner can drop a strobe. With no owner,
  // both masters striking together still count once.
  assign drop_evt = ((m0_reg_read | m0_reg_write) && (state != OWN0)) ||
                    ((m1_reg_read | m1_reg_write) && (state != OWN1));

  // Status registers; a clear overrides a same-cycle set or increment.
  always_ff @(posedge usb_clk or negedge reset_n) begin
    if (!reset_n) begin
      O_timeout       <= 1'b0;
      O_dropped_count <= 8'd0;
    end else if (I_clear_status) begin
      O_timeout       <= 1'b0;
      O_dropped_count <= 8'd0;
    end else begin
      if (state == REVOKE) O_timeout <= 1'b1;
      if (drop_evt && (O_dropped_count != 8'hFF)) O_dropped_count <= O_dropped_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_trace_reg_arbiter.sv
// tb_trace_reg_arbiter
//   Drives both masters of trace_reg_arbiter with directed scenarios and a
//   randomized phase. A cycle-level reference model tracks ownership, masking
//   and status. Forwarded slave accesses are queued as expectations and are
//   consumed by an independent monitor.
module tb_trace_reg_arbiter;

  localparam int AW      = 14;
  localparam int BW      = 7;
  localparam int TIMEOUT = 4;

  logic            usb_clk = 1'b0;
  logic            reset_n;
  logic [1:0]      req_v, rd_v, wr_v, av_v;
  logic [AW-1:0]   addr_v [2];
  logic [BW-1:0]   bc_v [2];
  logic [7:0]      wd_v [2];
  logic            clear_v;

  logic            m0_gnt, m1_gnt;
  logic [7:0]      m0_read_data, m1_read_data;
  logic [AW-1:0]   reg_address;
  logic [BW-1:0]   reg_bytecnt;
  logic [7:0]      write_data, read_data;
  logic            reg_read, reg_write, reg_addrvalid;
  logic [1:0]      O_owner;
  logic            O_timeout;
  logic [7:0]      O_dropped_count;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  typedef struct packed {
    logic          is_wr;
    logic          master;
    logic [AW-1:0] addr;
    logic [BW-1:0] bc;
    logic [7:0]    data;
  } exp_t;
  exp_t exp_q[$];

  // reference model state
  bit       own_valid, own_id, revoking, last_id;
  bit [1:0] blocked;
  int       stall, sticky_to, drops;

  always #5 usb_clk = ~usb_clk;

  // slave: read data is a simple function of the byte index
  assign read_data = reg_read ? (8'h41 + 8'(reg_bytecnt)) : 8'h00;

  trace_reg_arbiter #(
    .pADDR_WIDTH(21), .pBYTECNT_SIZE(7), .pTIMEOUT(TIMEOUT), .pTO_WIDTH(16)
  ) dut (
    .usb_clk(usb_clk), .reset_n(reset_n),
    .m0_req(req_v[0]), .m0_gnt(m0_gnt), .m0_address(addr_v[0]), .m0_bytecnt(bc_v[0]),
    .m0_write_data(wd_v[0]), .m0_reg_read(rd_v[0]), .m0_reg_write(wr_v[0]),
    .m0_reg_addrvalid(av_v[0]), .m0_read_data(m0_read_data),
    .m1_req(req_v[1]), .m1_gnt(m1_gnt), .m1_address(addr_v[1]), .m1_bytecnt(bc_v[1]),
    .m1_write_data(wd_v[1]), .m1_reg_read(rd_v[1]), .m1_reg_write(wr_v[1]),
    .m1_reg_addrvalid(av_v[1]), .m1_read_data(m1_read_data),
    .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .write_data(write_data),
    .reg_read(reg_read), .reg_write(reg_write), .reg_addrvalid(reg_addrvalid),
    .read_data(read_data), .I_clear_status(clear_v), .O_owner(O_owner),
    .O_timeout(O_timeout), .O_dropped_count(O_dropped_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assert_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    own_valid = 0; own_id = 0; revoking = 0; last_id = 1;
    blocked = 2'b00; stall = 0; sticky_to = 0; drops = 0;
  endtask

  // One clock of the arbitration rules, using the inputs present before the edge.
  task automatic model_update();
    bit s0, s1, e0, e1, nv, nid, nrev, own_strobe;
    s0 = rd_v[0] | wr_v[0];
    s1 = rd_v[1] | wr_v[1];
    if (clear_v) begin
      sticky_to = 0;
      drops     = 0;
    end else begin
      if (revoking) sticky_to = 1;
      if (((s0 && !(own_valid && !own_id)) || (s1 && !(own_valid && own_id))) && drops < 255)
        drops++;
    end
    e0 = req_v[0] && !blocked[0];
    e1 = req_v[1] && !blocked[1];
    nv = own_valid; nid = own_id; nrev = 0;
    own_strobe = own_id ? s1 : s0;
    if (revoking) begin
      nv = 0;
    end else if (!own_valid) begin
      if (e0 || e1) begin
        nv = 1;
        nid = (e0 && e1) ? !last_id : e1;
        last_id = nid;
        stall = 0;
      end
    end else if (!req_v[own_id]) begin
      nv = 0;
    end else if (own_strobe) begin
      stall = 0;
    end else begin
      stall++;
      if (TIMEOUT != 0 && stall >= TIMEOUT) begin
        nv = 0;
        nrev = 1;
      end
    end
    blocked = blocked & req_v;
    if (revoking) blocked[own_id] = 1'b1;
    own_valid = nv; own_id = nid; revoking = nrev;
  endtask

  // Record the slave access the current owner is about to make.
  task automatic commit();
    exp_t e;
    if (own_valid && (rd_v[own_id] || wr_v[own_id])) begin
      e.is_wr  = wr_v[own_id];
      e.master = own_id;
      e.addr   = addr_v[own_id];
      e.bc     = bc_v[own_id];
      e.data   = wd_v[own_id];
      exp_q.push_back(e);
    end
  endtask

  task automatic checkOutput();
    logic [1:0] exp_owner;
    exp_owner = own_valid ? (own_id ? 2'b10 : 2'b01) : 2'b00;
    check("m0_gnt", 32'(m0_gnt), 32'(exp_owner[0]));
    check("m1_gnt", 32'(m1_gnt), 32'(exp_owner[1]));
    check("O_owner", 32'(O_owner), 32'(exp_owner));
    check("O_timeout", 32'(O_timeout), sticky_to);
    check("O_dropped_count", 32'(O_dropped_count), drops);
    if (!own_valid) begin
      check("idle_slave_bus", {reg_read, reg_write, reg_addrvalid, reg_address, reg_bytecnt, write_data}, 0);
      check("idle_read_data", 32'({m0_read_data, m1_read_data}), 0);
    end else begin
      check("addrvalid", 32'(reg_addrvalid), 32'(av_v[own_id]));
      check("nonowner_read_data", 32'(own_id ? m0_read_data : m1_read_data), 0);
    end
  endtask

  task automatic run_cycle();
    commit();
    @(negedge usb_clk);
    checkOutput();
    @(posedge usb_clk);
    if (reset_n) model_update(); else model_reset();
    #1;
  endtask

  task automatic applyStimulus(input bit m, input bit req, input bit rd, input bit wr,
                               input logic [AW-1:0] addr, input logic [BW-1:0] bc,
                               input logic [7:0] data);
    req_v[m] = req; rd_v[m] = rd; wr_v[m] = wr; av_v[m] = rd | wr;
    addr_v[m] = addr; bc_v[m] = bc; wd_v[m] = data;
  endtask

  task automatic settle(input int n);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    clear_v = 1'b0;
    repeat (n) run_cycle();
  endtask

  task automatic wait_owner(input bit m, input int budget);
    int n;
    n = 0;
    while (!(own_valid && own_id == m) && n < budget) begin
      run_cycle();
      n++;
    end
    check("wait_gnt", 32'(m ? m1_gnt : m0_gnt), 1);
  endtask

  // Scoreboard monitor: every forwarded strobe must match the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge usb_clk);
      if (reset_n) begin
        if (reg_write || reg_read) begin
          if (exp_q.size() == 0) begin
            check("unexpected_strobe", 32'({reg_write, reg_read}), 0);
          end else begin
            e = exp_q.pop_front();
            check("sb_write", 32'(reg_write), 32'(e.is_wr));
            check("sb_read", 32'(reg_read), 32'(!e.is_wr));
            check("sb_addr", 32'(reg_address), 32'(e.addr));
            check("sb_bytecnt", 32'(reg_bytecnt), 32'(e.bc));
            if (e.is_wr) check("sb_wdata", 32'(write_data), 32'(e.data));
            else check("sb_rdata", 32'(e.master ? m1_read_data : m0_read_data), 32'(8'h41 + 8'(e.bc)));
          end
        end else if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("missing_strobe", 32'(reg_write | reg_read), 1);
        end
      end
    end
  end

  initial begin
    bit r0, r1;
    reset_n = 1'b0;
    model_reset();
    settle(3);
    reset_n = 1'b1;

    // tie from reset goes to M0, then M1, then M0 again; M1 reads 8 bytes
    req_v = 2'b11;
    run_cycle();
    check("tie1_m0_gnt", 32'(m0_gnt), 1);
    check("tie1_m1_gnt", 32'(m1_gnt), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 14'h0011, 7'd0, 8'h5A);
    run_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    run_cycle();
    run_cycle();
    check("rr_m1_gnt", 32'(m1_gnt), 1);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 14'h0020, 7'(i), 8'h00);
      run_cycle();
    end
    settle(2);
    req_v = 2'b11;
    run_cycle();
    check("tie2_m0_gnt", 32'(m0_gnt), 1);
    settle(3);

    // single write from M0
    settle(2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    run_cycle();
    check("s1_owner", 32'(O_owner), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 14'h0009, 7'd0, 8'h0F);
    run_cycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    run_cycle();
    run_cycle();
    check("s1_owner_after", 32'(O_owner), 0);

    // stall timeout on M0, M1 takes over, M0 stays masked until it lets go
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    run_cycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 14'h0033, 7'd1, 8'hC3);
    wait_owner(1'b1, 10);
    check("timeout_flag", 32'(O_timeout), 1);
    repeat (3) run_cycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (4) run_cycle();
    check("masked_m0_gnt", 32'(m0_gnt), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    run_cycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    wait_owner(1'b0, 4);
    settle(2);

    // M1 hammers reg_write while M0 owns
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    wait_owner(1'b0, 4);
    repeat (300) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, AW'($urandom), BW'($urandom), 8'($urandom));
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 14'h3FFF, 7'h7F, 8'hEE);
      run_cycle();
    end
    check("drop_sat", 32'(O_dropped_count), 255);
    clear_v = 1'b1;
    run_cycle();
    clear_v = 1'b0;
    check("drop_clear", 32'(O_dropped_count), 0);
    check("timeout_clear", 32'(O_timeout), 0);
    settle(2);

    // randomized traffic
    r0 = 0; r1 = 0;
    repeat (500) begin
      if ($urandom_range(0, 7) == 0) r0 = ~r0;
      if ($urandom_range(0, 7) == 0) r1 = ~r1;
      applyStimulus(1'b0, r0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                    AW'($urandom), BW'($urandom), 8'($urandom));
      applyStimulus(1'b1, r1, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                    AW'($urandom), BW'($urandom), 8'($urandom));
      clear_v = ($urandom_range(0, 40) == 0);
      run_cycle();
    end
    settle(3);

    // reset in the middle of an M0 burst
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    wait_owner(1'b0, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 14'h0123, 7'd3, 8'hA5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 14'h0001, 7'd0, 8'h00);
    run_cycle();
    run_cycle();
    #2 reset_n = 1'b0;
    #1;
    check("rst_m0_gnt", 32'(m0_gnt), 0);
    check("rst_reg_write", 32'(reg_write), 0);
    check("rst_write_data", 32'(write_data), 0);
    check("rst_owner", 32'(O_owner), 0);
    check("rst_dropped", 32'(O_dropped_count), 0);
    model_reset();
    exp_q.delete();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(posedge usb_clk);
    #1 reset_n = 1'b1;
    run_cycle();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, '0, '0, '0);
    wait_owner(1'b0, 4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 14'h0042, 7'd2, 8'h3C);
    run_cycle();
    settle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/trace_reg_arbiter.md
Name: trace_reg_arbiter

Overview:
- Shares the trace register-block slave interface between two masters:
  - M0: the USB register front-end.
  - M1: an on-chip configuration master, e.g. a pattern/mask autoloader.
- Grants whole multi-byte transactions, round-robin between the masters.
- Revokes a grant after a programmable stall, with sticky error reporting.
- Counts strobes dropped from the non-owning master.
- Sits between the masters and the trace register block, all in the usb_clk domain.

Parameters:
- pADDR_WIDTH, 21, full register address width including byte count.
- pBYTECNT_SIZE, 7, byte-count field width.
- pTIMEOUT, 1024, consecutive strobe-free owned cycles before revoke; 0 disables.
- pTO_WIDTH, 16, width of the stall counter.

Ports:
- usb_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- mN_req  in  1  master N (N=0,1) requests the bus.
- mN_gnt  out  1  master N owns the bus.
- mN_address  in  pADDR_WIDTH-pBYTECNT_SIZE  register address.
- mN_bytecnt  in  pBYTECNT_SIZE  byte count.
- mN_write_data  in  8  write byte.
- mN_reg_read  in  1  read strobe.
- mN_reg_write  in  1  write strobe.
- mN_reg_addrvalid  in  1  address valid.
- mN_read_data  out  8  read byte; zero unless owner.
- reg_address  out  pADDR_WIDTH-pBYTECNT_SIZE  to slave.
- reg_bytecnt  out  pBYTECNT_SIZE  to slave.
- write_data  out  8  to slave.
- reg_read  out  1  to slave.
- reg_write  out  1  to slave.
- reg_addrvalid  out  1  to slave.
- read_data  in  8  from slave; combinational, same cycle as reg_read.
- I_clear_status  in  1  clears O_timeout and O_dropped_count.
- O_owner  out  2  00 none, 01 M0, 10 M1.
- O_timeout  out  1  sticky revoke flag.
- O_dropped_count  out  8  saturating dropped-strobe count.

Behaviour:
- Reset: asynchronous on reset_n low. State IDLE. Both mN_gnt 0, O_owner 0, O_timeout 0, O_dropped_count 0, mask bits 0, last_owner=M1 (M0 wins the first tie), stall counter 0. All slave outputs 0. Reset mid-transaction aborts immediately and no strobe is forwarded.
- States: IDLE, OWN0, OWN1, REVOKE.
- IDLE transitions:
  - Requests are unmasked mN_req.
  - Exactly one requesting -> OWN of that master next cycle.
  - Both requesting -> grant the master != last_owner; update last_owner.
  - None -> stay in IDLE.
- Grant latency: req sampled high in IDLE at edge t -> mN_gnt high from t+1.
- OWNn:
  - Owner's address, bytecnt, write_data and strobes pass combinationally to the slave.
  - Slave read_data passes combinationally to the owner's mN_read_data.
  - If owner asserts read and write together, write is forwarded and read forced 0.
  - Owner drops req -> IDLE next cycle. IDLE lasts at least one cycle, so the earliest new grant is 2 cycles after the req drop.
- Idle state: slave strobes and addrvalid are 0; address, bytecnt and write_data are 0. Both mN_read_data are 0.
- Stall counter:
  - Cleared on grant and on any forwarded strobe.
  - Otherwise increments each owned cycle.
  - When pTIMEOUT!=0 and the counter reaches pTIMEOUT -> REVOKE next cycle.
- REVOKE (one cycle):
  - gnt low, no forwarding.
  - O_timeout <= 1.
  - Revoked master's mask bit set.
  - Then IDLE.
- Mask bit clears when that master's req is observed low. A masked master is never granted.
- Dropped count:
  - +1 per cycle in which any non-owner asserts reg_read or reg_write. Both non-owners together in IDLE still count +1.
  - Saturates at 255.
- I_clear_status: clears O_timeout and O_dropped_count. Clear wins over a same-cycle set/increment.
- O_owner is registered, consistent with mN_gnt.

Test Plan:
- M0 req at cycle 5, writes 0x0F to address 0x09 bytecnt 0, releases -> m0_gnt high cycles 6..release. Slave sees reg_write=1, write_data 0x0F in the strobe cycle. O_owner=01 during grant, 00 after.
- M0 and M1 req in the same cycle from reset -> M0 granted. After M0 releases, M1 granted 2 cycles later. Next tie -> M0 wins.
- M1 owns and reads 8 bytes, slave returns 0x41..0x48 -> m1_read_data matches the same cycle; m0_read_data stays 0.
- pTIMEOUT=4: M0 granted, holds req with no strobes -> REVOKE after 4 idle cycles, O_timeout=1. M1 granted while M0 stays masked; M0 is re-granted only after dropping and reasserting req.
- M1 pulses reg_write 300 times while M0 owns -> no slave write from M1. O_dropped_count=255. I_clear_status -> 0.
- Reset_n low mid-burst of M0 -> gnt, strobes and counters 0 immediately. After release, a fresh request is granted normally.
